// File: rtl/pcseq_pkg.sv
// Shared opcodes, FSM state encoding and control-field classifier for pc_sequencer.
package pcseq_pkg;

    localparam logic [3:0] OP_NOP     = 4'd0;
    localparam logic [3:0] OP_RET     = 4'd1;
    localparam logic [3:0] OP_CALL    = 4'd3;
    localparam logic [3:0] OP_JMP     = 4'd4;
    localparam logic [3:0] OP_JMPC_LO = 4'd5;
    localparam logic [3:0] OP_JMPC_HI = 4'd7;
    localparam logic [3:0] OP_WR_MASK = 4'b1000;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SQUASH = 2'd1,
        ST_FAULT  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        K_NOP  = 3'd0,
        K_RET  = 3'd1,
        K_CALL = 3'd2,
        K_JMP  = 3'd3,
        K_JMPC = 3'd4,
        K_ALU  = 3'd5
    } kind_e;

    // Reserved code 2 and code 0 both fall through to K_NOP.
    function automatic kind_e ret_kind(input logic [3:0] cont);
        kind_e k;
        k = K_NOP;
        if ((cont & OP_WR_MASK) != 4'd0) begin
            k = K_ALU;
        end else if (cont == OP_RET) begin
            k = K_RET;
        end else if (cont == OP_CALL) begin
            k = K_CALL;
        end else if (cont == OP_JMP) begin
            k = K_JMP;
        end else if ((cont >= OP_JMPC_LO) && (cont <= OP_JMPC_HI)) begin
            k = K_JMPC;
        end else begin
            k = K_NOP;
        end
        return k;
    endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address stack; PCSEQ_RSTACK_WRAP_EN makes it circular (overwrite oldest, stale pop).
module ret_stack
    import pcseq_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [AW-1:0] i_din,
    output logic [AW-1:0] o_dout,
    output logic          o_full,
    output logic          o_empty
);

    localparam int          PW      = $clog2(DEPTH);
    localparam logic [PW:0] SP_FULL = (PW+1)'(DEPTH);

    logic [AW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW:0]   r_sp;
    logic [PW-1:0] w_top;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_top   = r_wp - PW'(1);
    assign o_dout  = r_mem[w_top];
    assign o_full  = (r_sp == SP_FULL);
    assign o_empty = (r_sp == (PW+1)'(0));

`ifdef PCSEQ_RSTACK_WRAP_EN
    assign w_do_push = i_push;
    assign w_do_pop  = i_pop;
`else
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
`endif

    // Write pointer walks the ring; occupancy saturates at DEPTH and floors at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {AW{1'b0}};
            end
            r_wp <= {PW{1'b0}};
            r_sp <= {(PW+1){1'b0}};
        end else begin
            if (w_do_push) begin
                r_mem[r_wp] <= i_din;
                r_wp        <= r_wp + PW'(1);
            end else if (w_do_pop) begin
                r_wp <= r_wp - PW'(1);
            end else begin
                r_wp <= r_wp;
            end
            if (w_do_push && !o_full) begin
                r_sp <= r_sp + (PW+1)'(1);
            end else if (w_do_pop && !o_empty) begin
                r_sp <= r_sp - (PW+1)'(1);
            end else begin
                r_sp <= r_sp;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-PC sequencer with return stack and one-slot squash. Option macro: PCSEQ_RSTACK_WRAP_EN.
module pc_sequencer
    import pcseq_pkg::*;
#(
    parameter int            AW       = 8,
    parameter int            DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = {AW{1'b0}}
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_adv,
    input  logic [3:0]    i_cont,
    input  logic [AW-1:0] i_target,
    input  logic          i_tcnd,
    output logic [AW-1:0] o_pc,
    output logic [AW-1:0] o_dec_pc,
    output logic          o_squash,
    output logic          o_wen,
    output logic          o_fault
);

    state_e        r_state;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_dec_pc;
    logic          r_squash;
    logic          r_fault;

    kind_e         w_kind;
    logic          w_exec;
    logic          w_err;
    logic          w_redir;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [AW-1:0] w_dout;
    logic [AW-1:0] w_redir_pc;
    logic [AW-1:0] w_ret_addr;

    assign w_kind     = ret_kind(i_cont);
    assign w_exec     = i_adv && (r_state == ST_RUN);
    assign w_ret_addr = r_dec_pc + AW'(1);

`ifdef PCSEQ_RSTACK_WRAP_EN
    assign w_err = 1'b0;
`else
    assign w_err = ((w_kind == K_CALL) && w_full) || ((w_kind == K_RET) && w_empty);
`endif

    assign w_redir = (w_kind == K_JMP) || (w_kind == K_CALL) || (w_kind == K_RET) ||
                     ((w_kind == K_JMPC) && i_tcnd);
    assign w_push  = w_exec && !w_err && (w_kind == K_CALL);
    assign w_pop   = w_exec && !w_err && (w_kind == K_RET);

    // Redirect source: popped return address for RET, decode-slot target otherwise.
    always_comb begin
        w_redir_pc = i_target;
        case (w_kind)
            K_RET:   w_redir_pc = w_dout;
            default: w_redir_pc = i_target;
        endcase
    end

    ret_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_ret_addr),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Sequencing FSM: RUN executes, SQUASH discards one slot, FAULT freezes until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_RUN;
            r_pc     <= RESET_PC;
            r_dec_pc <= RESET_PC;
            r_squash <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_adv) begin
                        if (w_err) begin
                            r_state  <= ST_FAULT;
                            r_fault  <= 1'b1;
                            r_squash <= 1'b0;
                        end else if (w_redir) begin
                            r_pc     <= w_redir_pc;
                            r_dec_pc <= r_pc;
                            r_squash <= 1'b1;
                            r_state  <= ST_SQUASH;
                        end else begin
                            r_pc     <= r_pc + AW'(1);
                            r_dec_pc <= r_pc;
                            r_squash <= 1'b0;
                        end
                    end
                end
                ST_SQUASH: begin
                    if (i_adv) begin
                        r_pc     <= r_pc + AW'(1);
                        r_dec_pc <= r_pc;
                        r_squash <= 1'b0;
                        r_state  <= ST_RUN;
                    end
                end
                ST_FAULT: begin
                    r_squash <= 1'b0;
                    r_fault  <= 1'b1;
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_squash <= 1'b0;
                end
            endcase
        end
    end

    assign o_pc     = r_pc;
    assign o_dec_pc = r_dec_pc;
    assign o_squash = r_squash;
    assign o_fault  = r_fault;
    assign o_wen    = rst_n && i_adv && (r_state == ST_RUN) && (w_kind == K_ALU);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer (AW=8, DEPTH=4, RESET_PC=0).
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       adv;
    logic [3:0] cont;
    logic [7:0] target;
    logic       tcnd;
    logic [7:0] pc;
    logic [7:0] dec_pc;
    logic       squash;
    logic       wen;
    logic       fault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       adv;
        logic [3:0] cont;
        logic [7:0] target;
        logic       tcnd;
        logic       wen;
        logic [7:0] pc;
        logic [7:0] dec_pc;
        logic       squash;
    } vec_t;

    vec_t vecs [42];

    pc_sequencer #(.AW(8), .DEPTH(4), .RESET_PC(8'h00)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_adv    (adv),
        .i_cont   (cont),
        .i_target (target),
        .i_tcnd   (tcnd),
        .o_pc     (pc),
        .o_dec_pc (dec_pc),
        .o_squash (squash),
        .o_wen    (wen),
        .o_fault  (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Apply one decode-slot instruction, check wen before the edge, return #1 after it.
    task automatic step(input logic a, input logic [3:0] c, input logic [7:0] t,
                        input logic tc, input logic ew, input string nm);
        adv = a; cont = c; target = t; tcnd = tc;
        #1;
        chk({nm, " wen"}, {31'd0, wen}, {31'd0, ew});
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse(input string nm);
        adv = 1'b1; cont = 4'd8; target = 8'h00; tcnd = 1'b0;
        rst_n = 1'b0;
        #1;
        chk({nm, " pc"},     {24'd0, pc},     32'h0);
        chk({nm, " dec_pc"}, {24'd0, dec_pc}, 32'h0);
        chk({nm, " squash"}, {31'd0, squash}, 32'h0);
        chk({nm, " fault"},  {31'd0, fault},  32'h0);
        chk({nm, " wen"},    {31'd0, wen},    32'h0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 8'h01, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 8'h02, 8'h01, 1'b0};
        vecs[2]  = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 8'h03, 8'h02, 1'b0};
        vecs[3]  = '{1'b1, 4'd8, 8'h00, 1'b0, 1'b1, 8'h04, 8'h03, 1'b0};
        vecs[4]  = '{1'b1, 4'd9, 8'h00, 1'b0, 1'b1, 8'h05, 8'h04, 1'b0};
        vecs[5]  = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 8'h06, 8'h05, 1'b0};
        vecs[6]  = '{1'b1, 4'd4, 8'h40, 1'b0, 1'b0, 8'h40, 8'h06, 1'b1};
        vecs[7]  = '{1'b1, 4'd8, 8'h00, 1'b0, 1'b0, 8'h41, 8'h40, 1'b0};
        vecs[8]  = '{1'b1, 4'd5, 8'h99, 1'b0, 1'b0, 8'h42, 8'h41, 1'b0};
        vecs[9]  = '{1'b1, 4'd7, 8'h80, 1'b1, 1'b0, 8'h80, 8'h42, 1'b1};
        vecs[10] = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 8'h81, 8'h80, 1'b0};
        vecs[11] = '{1'b1, 4'd6, 8'h90, 1'b0, 1'b0, 8'h82, 8'h81, 1'b0};
        vecs[12] = '{1'b1, 4'd4, 8'h10, 1'b0, 1'b0, 8'h10, 8'h82, 1'b1};
        vecs[13] = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 8'h11, 8'h10, 1'b0};
        vecs[14] = '{1'b1, 4'd3, 8'h20, 1'b0, 1'b0, 8'h20, 8'h11, 1'b1};
        vecs[15] = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 8'h21, 8'h20, 1'b0};
        vecs[16] = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 8'h22, 8'h21, 1'b0};
        vecs[17] = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 8'h23, 8'h22, 1'b0};
        vecs[18] = '{1'b1, 4'd1, 8'h55, 1'b0, 1'b0, 8'h11, 8'h23, 1'b1};
        vecs[19] = '{1'b1, 4'd8, 8'h00, 1'b0, 1'b0, 8'h12, 8'h11, 1'b0};
        vecs[20] = '{1'b1, 4'd3, 8'h30, 1'b0, 1'b0, 8'h30, 8'h12, 1'b1};
        vecs[21] = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 8'h31, 8'h30, 1'b0};
        vecs[22] = '{1'b1, 4'd3, 8'h50, 1'b0, 1'b0, 8'h50, 8'h31, 1'b1};
        vecs[23] = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 8'h51, 8'h50, 1'b0};
        vecs[24] = '{1'b1, 4'd3, 8'h70, 1'b0, 1'b0, 8'h70, 8'h51, 1'b1};
        vecs[25] = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 8'h71, 8'h70, 1'b0};
        vecs[26] = '{1'b1, 4'd3, 8'hA0, 1'b0, 1'b0, 8'hA0, 8'h71, 1'b1};
        vecs[27] = '{1'b0, 4'd8, 8'h00, 1'b0, 1'b0, 8'hA0, 8'h71, 1'b1};
        vecs[28] = '{1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 8'hA0, 8'h71, 1'b1};
        vecs[29] = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 8'hA1, 8'hA0, 1'b0};
        vecs[30] = '{1'b1, 4'd1, 8'h00, 1'b0, 1'b0, 8'h71, 8'hA1, 1'b1};
        vecs[31] = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 8'h72, 8'h71, 1'b0};
        vecs[32] = '{1'b1, 4'd1, 8'h00, 1'b0, 1'b0, 8'h51, 8'h72, 1'b1};
        vecs[33] = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 8'h52, 8'h51, 1'b0};
        vecs[34] = '{1'b1, 4'd1, 8'h00, 1'b0, 1'b0, 8'h31, 8'h52, 1'b1};
        vecs[35] = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 8'h32, 8'h31, 1'b0};
        vecs[36] = '{1'b1, 4'd1, 8'h00, 1'b0, 1'b0, 8'h12, 8'h32, 1'b1};
        vecs[37] = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 8'h13, 8'h12, 1'b0};
        vecs[38] = '{1'b0, 4'd9, 8'h00, 1'b0, 1'b0, 8'h13, 8'h12, 1'b0};
        vecs[39] = '{1'b1, 4'd4, 8'hFE, 1'b0, 1'b0, 8'hFE, 8'h13, 1'b1};
        vecs[40] = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 8'hFF, 8'hFE, 1'b0};
        vecs[41] = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0};

        // Power-on reset, checked while rst_n is still low.
        rst_n = 1'b0; adv = 1'b1; cont = 4'd8; target = 8'h00; tcnd = 1'b0;
        #3;
        chk("por pc",     {24'd0, pc},     32'h0);
        chk("por dec_pc", {24'd0, dec_pc}, 32'h0);
        chk("por squash", {31'd0, squash}, 32'h0);
        chk("por fault",  {31'd0, fault},  32'h0);
        chk("por wen",    {31'd0, wen},    32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 42; i++) begin
            step(vecs[i].adv, vecs[i].cont, vecs[i].target, vecs[i].tcnd, vecs[i].wen,
                 $sformatf("vec%0d", i));
            chk($sformatf("vec%0d pc", i),     {24'd0, pc},     {24'd0, vecs[i].pc});
            chk($sformatf("vec%0d dec_pc", i), {24'd0, dec_pc}, {24'd0, vecs[i].dec_pc});
            chk($sformatf("vec%0d squash", i), {31'd0, squash}, {31'd0, vecs[i].squash});
            chk($sformatf("vec%0d fault", i),  {31'd0, fault},  32'h0);
        end

        // Four nested calls fill the stack; the fifth overflows.
        reset_pulse("rstA");
        for (int k = 0; k < 4; k++) begin
            logic [7:0] t;
            t = 8'((k + 1) * 16);
            step(1'b1, 4'd3, t, 1'b0, 1'b0, $sformatf("call%0d", k));
            chk($sformatf("call%0d pc", k),     {24'd0, pc},     {24'd0, t});
            chk($sformatf("call%0d squash", k), {31'd0, squash}, 32'h1);
            step(1'b1, 4'd0, 8'h00, 1'b0, 1'b0, $sformatf("call%0d slot", k));
            chk($sformatf("call%0d slot pc", k), {24'd0, pc}, {24'd0, t + 8'h01});
            chk($sformatf("call%0d fault", k),   {31'd0, fault}, 32'h0);
        end
        step(1'b1, 4'd3, 8'hC0, 1'b0, 1'b0, "call5");
`ifdef PCSEQ_RSTACK_WRAP_EN
        chk("call5 fault",  {31'd0, fault},  32'h0);
        chk("call5 pc",     {24'd0, pc},     32'hC0);
        chk("call5 squash", {31'd0, squash}, 32'h1);
        step(1'b1, 4'd0, 8'h00, 1'b0, 1'b0, "call5 slot");
        begin
            logic [7:0] ret_exp [4];
            ret_exp[0] = 8'h41; ret_exp[1] = 8'h31; ret_exp[2] = 8'h21; ret_exp[3] = 8'h11;
            for (int j = 0; j < 4; j++) begin
                step(1'b1, 4'd1, 8'h00, 1'b0, 1'b0, $sformatf("wret%0d", j));
                chk($sformatf("wret%0d pc", j), {24'd0, pc}, {24'd0, ret_exp[j]});
                step(1'b1, 4'd0, 8'h00, 1'b0, 1'b0, $sformatf("wret%0d slot", j));
            end
        end
`else
        chk("ovf fault",  {31'd0, fault},  32'h1);
        chk("ovf pc",     {24'd0, pc},     32'h41);
        chk("ovf dec_pc", {24'd0, dec_pc}, 32'h40);
        chk("ovf squash", {31'd0, squash}, 32'h0);
        step(1'b1, 4'd8, 8'h00, 1'b0, 1'b0, "ovf alu8");
        chk("ovf alu8 pc", {24'd0, pc}, 32'h41);
        step(1'b1, 4'd15, 8'h00, 1'b0, 1'b0, "ovf alu15");
        step(1'b1, 4'd4, 8'h77, 1'b0, 1'b0, "ovf jmp");
        chk("ovf jmp pc",    {24'd0, pc},     32'h41);
        chk("ovf jmp fault", {31'd0, fault},  32'h1);
        chk("ovf jmp sq",    {31'd0, squash}, 32'h0);
`endif

        // Reset out of FAULT, then again in the middle of a squash slot.
        reset_pulse("rstB");
        step(1'b1, 4'd4, 8'h33, 1'b0, 1'b0, "pre-rst jmp");
        chk("pre-rst jmp pc", {24'd0, pc},     32'h33);
        chk("pre-rst jmp sq", {31'd0, squash}, 32'h1);
        reset_pulse("rst mid-squash");
        step(1'b1, 4'd1, 8'h00, 1'b0, 1'b0, "unf ret");
`ifdef PCSEQ_RSTACK_WRAP_EN
        chk("unf fault", {31'd0, fault}, 32'h0);
`else
        chk("unf fault",  {31'd0, fault},  32'h1);
        chk("unf pc",     {24'd0, pc},     32'h0);
        chk("unf dec_pc", {24'd0, dec_pc}, 32'h0);
        chk("unf squash", {31'd0, squash}, 32'h0);
        step(1'b1, 4'd8, 8'h00, 1'b0, 1'b0, "unf alu");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
